// File: rtl/bypass_pkg.sv
// Shared types for the operand bypass network: in-flight entry layout,
// forward-source encoding and ALU source selector values.
package bypass_pkg;

  // Entry fields are sized for the widest supported datapath/register space.
  localparam int unsigned ENTRY_DW = 64;
  localparam int unsigned ENTRY_AW = 8;

  localparam logic ALU_SRC_GPR = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EX,
    FWD_MEM_LOAD,
    FWD_ENTRY
  } fwd_src_t;

  typedef struct packed {
    logic                valid;
    logic [ENTRY_AW-1:0] rd;
    logic                we;
    logic                is_load;
    logic                ready;
    logic [ENTRY_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/bypass_select.sv
// Per-operand priority match over the in-flight entries: picks the youngest
// producer of rs and returns its value, a hit flag and a load-use hazard flag.
module bypass_select
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]  rs,
  input  logic [XLEN-1:0]    gpr_value,
  input  logic [XLEN-1:0]    ex_result,
  input  logic [XLEN-1:0]    mem_load_data,
  output logic [XLEN-1:0]    value_c,
  output logic               hit_c,
  output logic               hazard_c
);

  fwd_src_t        src;
  logic [XLEN-1:0] stored;

  // Oldest first, so younger matches overwrite and win.
  always_comb begin
    src      = FWD_NONE;
    stored   = '0;
    hazard_c = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].we && (rs != '0) &&
          (REG_AW'(entries[k].rd) == rs)) begin
        hazard_c = 1'b0;
        stored   = XLEN'(entries[k].data);
        if (k == 0) begin
          src      = FWD_EX;
          hazard_c = entries[k].is_load;
        end else if (k == 1 && entries[k].is_load && !entries[k].ready) begin
          src = FWD_MEM_LOAD;
        end else begin
          src = FWD_ENTRY;
        end
      end
    end
  end

  always_comb begin
    value_c = gpr_value;
    case (src)
      FWD_EX:       value_c = ex_result;
      FWD_MEM_LOAD: value_c = mem_load_data;
      FWD_ENTRY:    value_c = stored;
      default:      value_c = gpr_value;
    endcase
  end

  assign hit_c = (src != FWD_NONE);

endmodule

// File: rtl/operand_bypass_unit.sv
// Execute-stage operand bypass: tracks in-flight producers, resolves operands,
// stalls on load-use. Optional counters via RVCAM_BYPASS_STATS_EN.
module operand_bypass_unit
  import bypass_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic                      issue_rd_we,
  input  logic                      issue_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] issue_rs,
  input  logic [NUM_SRC*XLEN-1:0]   gpr_value,
  input  logic [XLEN-1:0]           imm,
  input  logic [NUM_SRC-1:0]        alu_src,
  input  logic [XLEN-1:0]           ex_result,
  input  logic [XLEN-1:0]           mem_load_data,
  input  logic                      flush,
`ifdef RVCAM_BYPASS_STATS_EN
  output logic [31:0]               fwd_count,
  output logic [31:0]               stall_count,
`endif
  output logic                      op_valid,
  output logic [NUM_SRC*XLEN-1:0]   operand,
  output logic [NUM_SRC*XLEN-1:0]   src_value,
  output logic [NUM_SRC-1:0]        fwd_hit
);

  entry_t [DEPTH-1:0]           entries;
  entry_t [DEPTH-1:0]           next_entries;
  logic [NUM_SRC-1:0][XLEN-1:0] sel_value;
  logic [NUM_SRC-1:0][XLEN-1:0] operand_c;
  logic [NUM_SRC-1:0]           sel_hit;
  logic [NUM_SRC-1:0]           sel_hazard;
  logic [NUM_SRC-1:0]           stall_src;
  logic                         hazard_c;
  logic                         accept_c;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    bypass_select #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
    ) u_sel (
      .entries       (entries),
      .rs            (issue_rs[s*REG_AW +: REG_AW]),
      .gpr_value     (gpr_value[s*XLEN +: XLEN]),
      .ex_result     (ex_result),
      .mem_load_data (mem_load_data),
      .value_c       (sel_value[s]),
      .hit_c         (sel_hit[s]),
      .hazard_c      (sel_hazard[s])
    );

    // Immediate-selected sources never stall, even against a load in EX.
    assign stall_src[s] = sel_hazard[s] && (alu_src[s] == ALU_SRC_GPR);
    assign operand_c[s] = (alu_src[s] == ALU_SRC_IMM) ? imm : sel_value[s];
  end

  assign hazard_c    = |stall_src;
  assign issue_ready = !hazard_c;
  assign accept_c    = issue_valid && issue_ready && !flush;

  // Pipeline advances every cycle; data is captured as entries leave EX/MEM.
  always_comb begin
    next_entries = entries;
    next_entries[0] = '0;
    if (accept_c) begin
      next_entries[0].valid   = 1'b1;
      next_entries[0].rd      = ENTRY_AW'(issue_rd);
      next_entries[0].we      = issue_rd_we;
      next_entries[0].is_load = issue_is_load;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      next_entries[k] = entries[k-1];
      if (k == 1) begin
        next_entries[k].valid = entries[k-1].valid && !flush;
        if (entries[k-1].is_load) begin
          next_entries[k].ready = 1'b0;
        end else begin
          next_entries[k].data  = ENTRY_DW'(ex_result);
          next_entries[k].ready = 1'b1;
        end
      end else if (k == 2 && entries[k-1].is_load) begin
        next_entries[k].data  = ENTRY_DW'(mem_load_data);
        next_entries[k].ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else begin
      entries <= next_entries;
    end
  end

  // Data outputs hold between accepts; only op_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid  <= 1'b0;
      operand   <= '0;
      src_value <= '0;
      fwd_hit   <= '0;
    end else begin
      op_valid <= accept_c;
      if (accept_c) begin
        operand   <= operand_c;
        src_value <= sel_value;
        fwd_hit   <= sel_hit;
      end
    end
  end

`ifdef RVCAM_BYPASS_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (accept_c && (|sel_hit) && (fwd_count != '1)) begin
        fwd_count <= fwd_count + 32'd1;
      end
      if (issue_valid && hazard_c && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Scoreboard bench for operand_bypass_unit: expected operands are queued at
// issue and compared when the registered outputs appear one cycle later.
module tb_operand_bypass_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DEPTH   = 3;
  localparam int unsigned REG_AW  = 5;

  logic                      clk;
  logic                      rst_n;
  logic                      issue_valid;
  logic                      issue_ready;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_rd_we;
  logic                      issue_is_load;
  logic [NUM_SRC*REG_AW-1:0] issue_rs;
  logic [NUM_SRC*XLEN-1:0]   gpr_value;
  logic [XLEN-1:0]           imm;
  logic [NUM_SRC-1:0]        alu_src;
  logic [XLEN-1:0]           ex_result;
  logic [XLEN-1:0]           mem_load_data;
  logic                      flush;
  logic                      op_valid;
  logic [NUM_SRC*XLEN-1:0]   operand;
  logic [NUM_SRC*XLEN-1:0]   src_value;
  logic [NUM_SRC-1:0]        fwd_hit;
`ifdef RVCAM_BYPASS_STATS_EN
  logic [31:0]               fwd_count;
  logic [31:0]               stall_count;
`endif

  operand_bypass_unit #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .REG_AW  (REG_AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rd      (issue_rd),
    .issue_rd_we   (issue_rd_we),
    .issue_is_load (issue_is_load),
    .issue_rs      (issue_rs),
    .gpr_value     (gpr_value),
    .imm           (imm),
    .alu_src       (alu_src),
    .ex_result     (ex_result),
    .mem_load_data (mem_load_data),
    .flush         (flush),
`ifdef RVCAM_BYPASS_STATS_EN
    .fwd_count     (fwd_count),
    .stall_count   (stall_count),
`endif
    .op_valid      (op_valid),
    .operand       (operand),
    .src_value     (src_value),
    .fwd_hit       (fwd_hit)
  );

  typedef struct {
    logic        v;
    logic [63:0] op;
    logic [63:0] sv;
    logic [1:0]  hit;
    logic        chk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] op1, input logic [31:0] op0,
                              input logic [31:0] sv1, input logic [31:0] sv0,
                              input logic [1:0] hit, input logic chk);
    exp_t e;
    e.v   = v;
    e.op  = {op1, op0};
    e.sv  = {sv1, sv0};
    e.hit = hit;
    e.chk = chk;
    return e;
  endfunction

  function automatic exp_t mk_op(input logic [31:0] op1, input logic [31:0] op0, input logic [1:0] hit);
    return mk(1'b1, op1, op0, op1, op0, hit, 1'b1);
  endfunction

  function automatic exp_t mk_none();
    return mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
  endfunction

  task automatic idle_inputs();
    issue_valid   = 1'b0;
    issue_rd      = '0;
    issue_rd_we   = 1'b0;
    issue_is_load = 1'b0;
    issue_rs      = '0;
    gpr_value     = '0;
    imm           = '0;
    alu_src       = '0;
    ex_result     = '0;
    mem_load_data = '0;
    flush         = 1'b0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic we, input logic ld,
                           input logic [4:0] rs0, input logic [4:0] rs1);
    idle_inputs();
    issue_valid   = 1'b1;
    issue_rd      = rd;
    issue_rd_we   = we;
    issue_is_load = ld;
    issue_rs      = {rs1, rs0};
  endtask

  task automatic set_gpr(input logic [31:0] g0, input logic [31:0] g1);
    gpr_value = {g1, g0};
  endtask

  task automatic sb_pop(input string tag);
    exp_t x;
    x = q.pop_front();
    check_eq({tag, ".op_valid"}, 64'(op_valid), 64'(x.v));
    if (x.v) begin
      check_eq({tag, ".operand"}, operand, x.op);
      if (x.chk) begin
        check_eq({tag, ".src_value"}, src_value, x.sv);
        check_eq({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(x.hit));
      end
    end
  endtask

  // Inputs are applied just after a rising edge; outputs sampled 1 ns after the next.
  task automatic cyc(input string tag, input logic exp_ready, input exp_t e);
    #1;
    check_eq({tag, ".issue_ready"}, 64'(issue_ready), 64'(exp_ready));
    q.push_back(e);
    @(posedge clk);
    #1;
    sb_pop(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      cyc("idle", 1'b1, mk_none());
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.op_valid", 64'(op_valid), 64'd0);
    check_eq("rst.operand", operand, 64'd0);
    check_eq("rst.src_value", src_value, 64'd0);
    check_eq("rst.fwd_hit", 64'(fwd_hit), 64'd0);
    check_eq("rst.issue_ready", 64'(issue_ready), 64'd1);
    rst_n = 1'b1;

    // Plain GPR read.
    set_issue(5'd0, 1'b0, 1'b0, 5'd3, 5'd0); set_gpr(32'h11, 32'h22);
    cyc("s1", 1'b1, mk_op(32'h22, 32'h11, 2'b00));
    idle(3);

    // EX-stage ALU forward.
    set_issue(5'd5, 1'b1, 1'b0, 5'd1, 5'd2); set_gpr(32'h101, 32'h202);
    cyc("s2a", 1'b1, mk_op(32'h202, 32'h101, 2'b00));
    set_issue(5'd0, 1'b0, 1'b0, 5'd5, 5'd6); set_gpr(32'h301, 32'h302); ex_result = 32'hAA;
    cyc("s2b", 1'b1, mk_op(32'h302, 32'hAA, 2'b01));
    idle(3);

    // Load-use: one stall cycle, then mem_load_data forward.
    set_issue(5'd7, 1'b1, 1'b1, 5'd0, 5'd0); set_gpr(32'h10, 32'h20);
    cyc("s3a", 1'b1, mk_op(32'h20, 32'h10, 2'b00));
    set_issue(5'd0, 1'b0, 1'b0, 5'd1, 5'd7); set_gpr(32'h30, 32'h40);
    cyc("s3b", 1'b0, mk_none());
    set_issue(5'd0, 1'b0, 1'b0, 5'd1, 5'd7); set_gpr(32'h30, 32'h40); mem_load_data = 32'h1234;
    cyc("s3c", 1'b1, mk_op(32'h1234, 32'h30, 2'b10));
    idle(3);

    // rd reuse: youngest producer wins, both from EX and from stored data.
    set_issue(5'd4, 1'b1, 1'b0, 5'd0, 5'd0); set_gpr(32'h50, 32'h60);
    cyc("s4a", 1'b1, mk_op(32'h60, 32'h50, 2'b00));
    set_issue(5'd4, 1'b1, 1'b0, 5'd0, 5'd0); set_gpr(32'h50, 32'h60); ex_result = 32'h1;
    cyc("s4b", 1'b1, mk_op(32'h60, 32'h50, 2'b00));
    set_issue(5'd0, 1'b0, 1'b0, 5'd4, 5'd0); set_gpr(32'h50, 32'h60); ex_result = 32'h2;
    cyc("s4c", 1'b1, mk_op(32'h60, 32'h2, 2'b01));
    idle_inputs(); ex_result = 32'h777;
    cyc("s4d", 1'b1, mk_none());
    set_issue(5'd0, 1'b0, 1'b0, 5'd4, 5'd0); set_gpr(32'h50, 32'h60); ex_result = 32'hDEAD;
    cyc("s4e", 1'b1, mk_op(32'h60, 32'h2, 2'b01));
    idle(3);

    // x0 never forwards; immediate select keeps forwarded value on src_value.
    set_issue(5'd0, 1'b1, 1'b0, 5'd0, 5'd0); set_gpr(32'h77, 32'h88);
    cyc("s5a", 1'b1, mk_op(32'h88, 32'h77, 2'b00));
    set_issue(5'd8, 1'b1, 1'b0, 5'd0, 5'd0); set_gpr(32'h77, 32'h88); ex_result = 32'h99;
    cyc("s5b", 1'b1, mk_op(32'h88, 32'h77, 2'b00));
    set_issue(5'd9, 1'b1, 1'b1, 5'd8, 5'd8); set_gpr(32'h1, 32'h2);
    alu_src = 2'b01; imm = 32'hFFF; ex_result = 32'h5A5A;
    cyc("s5c", 1'b1, mk(1'b1, 32'h5A5A, 32'hFFF, 32'h5A5A, 32'h5A5A, 2'b11, 1'b1));
    set_issue(5'd0, 1'b0, 1'b0, 5'd9, 5'd0); set_gpr(32'h3, 32'h4);
    alu_src = 2'b01; imm = 32'h123; ex_result = 32'h3C;
    cyc("s5d", 1'b1, mk(1'b1, 32'h4, 32'h123, 32'h0, 32'h0, 2'b00, 1'b0));
    idle(3);

    // Flush kills the issuing instruction.
    set_issue(5'd9, 1'b1, 1'b0, 5'd0, 5'd0); set_gpr(32'h1, 32'h2); flush = 1'b1;
    cyc("s6a", 1'b1, mk_none());
    set_issue(5'd0, 1'b0, 1'b0, 5'd9, 5'd0); set_gpr(32'h66, 32'h67); ex_result = 32'hBAD;
    cyc("s6b", 1'b1, mk_op(32'h67, 32'h66, 2'b00));
    idle(3);

    // Flush kills the EX entry but leaves older entries intact.
    set_issue(5'd11, 1'b1, 1'b0, 5'd0, 5'd0);
    cyc("s6c", 1'b1, mk_op(32'h0, 32'h0, 2'b00));
    set_issue(5'd10, 1'b1, 1'b0, 5'd0, 5'd0); ex_result = 32'hE11;
    cyc("s6d", 1'b1, mk_op(32'h0, 32'h0, 2'b00));
    set_issue(5'd13, 1'b1, 1'b0, 5'd0, 5'd0); ex_result = 32'hE10; flush = 1'b1;
    cyc("s6e", 1'b1, mk_none());
    set_issue(5'd0, 1'b0, 1'b0, 5'd10, 5'd11); set_gpr(32'hA0, 32'hB0); ex_result = 32'hE13;
    cyc("s6f", 1'b1, mk_op(32'hE11, 32'hA0, 2'b10));
    idle(3);

`ifdef RVCAM_BYPASS_STATS_EN
    check_eq("stats.stall_count", 64'(stall_count), 64'd1);
`endif

    // Mid-operation reset discards the in-flight entry.
    set_issue(5'd12, 1'b1, 1'b0, 5'd0, 5'd0); set_gpr(32'h5, 32'h6);
    cyc("s7a", 1'b1, mk_op(32'h6, 32'h5, 2'b00));
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("s7.rst.op_valid", 64'(op_valid), 64'd0);
    check_eq("s7.rst.operand", operand, 64'd0);
    check_eq("s7.rst.src_value", src_value, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_inputs();
    cyc("s7b", 1'b1, mk_none());
    set_issue(5'd0, 1'b0, 1'b0, 5'd12, 5'd0); set_gpr(32'hC0, 32'hC1); ex_result = 32'hBEEF;
    cyc("s7c", 1'b1, mk_op(32'hC1, 32'hC0, 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
